// File: rtl/mac_align_pkg.sv
// Shared defaults, FSM state type and per-beat flag bundle for the multiply/align/accumulate pipeline.
package mac_align_pkg;

    localparam int LANES_DEF = 4;
    localparam int AW_DEF    = 27;
    localparam int BW_DEF    = 27;
    localparam int GW_DEF    = 16;
    localparam int SFTW_DEF  = 6;
    localparam int ACCW_DEF  = 82;
    localparam int CNTW_DEF  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    typedef struct packed {
        logic first;
        logic last;
        logic sub;
    } beat_flags_t;

endpackage

// File: rtl/mac_align_lane.sv
// One product lane: S1 unsigned multiply, S2 guard-bit extension and logical right align.
module mac_align_lane
    import mac_align_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int BW   = BW_DEF,
    parameter int GW   = GW_DEF,
    parameter int SFTW = SFTW_DEF
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [AW-1:0]         i_a,
    input  logic [BW-1:0]         i_b,
    input  logic [SFTW-1:0]       i_sft,
    output logic [AW+BW+GW-1:0]   o_aln
);

    logic [AW+BW-1:0]    r_prod;
    logic [SFTW-1:0]     r_sft;
    logic [AW+BW+GW-1:0] r_aln;

    // The shift amount rides alongside the product so S2 uses the beat's own value.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_prod <= (AW+BW)'(i_a) * (AW+BW)'(i_b);
            r_sft  <= i_sft;
            r_aln  <= {r_prod, {GW{1'b0}}} >> r_sft;
        end
    end

    assign o_aln = r_aln;

endmodule

// File: rtl/mac_align_acc.sv
// Multi-lane multiply/align/accumulate top: lane adder tree, S3 group accumulator, FSM, output register.
// Optional build macro MAC_ALIGN_SAT_EN: saturating accumulator with sticky per-group ovf flag.
module mac_align_acc
    import mac_align_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int AW    = AW_DEF,
    parameter int BW    = BW_DEF,
    parameter int GW    = GW_DEF,
    parameter int SFTW  = SFTW_DEF,
    parameter int ACCW  = ACCW_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic                    in_sub,
    input  logic [LANES*AW-1:0]     in_a,
    input  logic [LANES*BW-1:0]     in_b,
    input  logic [LANES*SFTW-1:0]   in_sft,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACCW-1:0]         out_acc,
    output logic [CNTW-1:0]         out_cnt,
    output logic                    proto_err,
    output logic                    ovf
);

    localparam int PW   = AW + BW + GW;
    localparam int SUMW = PW + $clog2(LANES);

    logic              w_en;
    logic [PW-1:0]     w_aln [LANES];
    logic [SUMW-1:0]   w_sum;

    logic              r_s1_valid, r_s2_valid;
    beat_flags_t       r_s1_flags, r_s2_flags;

    state_t            r_state, w_state_n;
    logic [ACCW-1:0]   r_acc, w_acc_n, w_base, w_term;
    logic [CNTW-1:0]   r_cnt, w_cnt_n, w_cnt_base;
    logic              w_beat, w_start, w_emit, w_err;

    logic              r_out_valid, r_proto_err;
    logic [ACCW-1:0]   r_out_acc;
    logic [CNTW-1:0]   r_out_cnt;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_align_lane #(.AW(AW), .BW(BW), .GW(GW), .SFTW(SFTW)) u_lane (
            .clk   (clk),
            .i_en  (w_en),
            .i_a   (in_a[g*AW +: AW]),
            .i_b   (in_b[g*BW +: BW]),
            .i_sft (in_sft[g*SFTW +: SFTW]),
            .o_aln (w_aln[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s1_flags <= '{first: in_first, last: in_last, sub: in_sub};
            r_s2_flags <= r_s1_flags;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + SUMW'(w_aln[i]);
        end
    end

    assign w_beat = w_en && r_s2_valid;

    // A beat seen in IDLE always opens a group, even when first is missing.
    always_comb begin
        w_state_n = r_state;
        w_start   = 1'b0;
        w_emit    = 1'b0;
        w_err     = 1'b0;
        if (w_beat) begin
            w_start   = r_s2_flags.first || (r_state == IDLE);
            w_emit    = r_s2_flags.last;
            w_state_n = r_s2_flags.last ? IDLE : ACC;
            case (r_state)
                IDLE: w_err = !r_s2_flags.first;
                ACC:  w_err = r_s2_flags.first;
            endcase
        end
    end

    assign w_base     = w_start ? '0 : r_acc;
    assign w_term     = r_s2_flags.sub ? -ACCW'(w_sum) : ACCW'(w_sum);
    assign w_cnt_base = w_start ? '0 : r_cnt;
    assign w_cnt_n    = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNTW'(1);

`ifdef MAC_ALIGN_SAT_EN
    logic [ACCW:0] w_ext;
    logic          w_ovf_beat;
    logic          r_ovf;

    // One extra bit exposes signed overflow as a disagreement of the top two bits.
    assign w_ext      = {w_base[ACCW-1], w_base} + {w_term[ACCW-1], w_term};
    assign w_ovf_beat = w_ext[ACCW] ^ w_ext[ACCW-1];
    assign w_acc_n    = !w_ovf_beat   ? w_ext[ACCW-1:0] :
                        w_ext[ACCW]   ? {1'b1, {(ACCW-1){1'b0}}} :
                                        {1'b0, {(ACCW-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_ovf <= (w_start ? 1'b0 : r_ovf) | w_ovf_beat;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_acc_n = w_base + w_term;
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_cnt   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_err;
            if (w_en) begin
                r_out_valid <= w_emit;
            end
            if (w_beat) begin
                r_state <= w_state_n;
                r_acc   <= w_acc_n;
                r_cnt   <= w_cnt_n;
                if (w_emit) begin
                    r_out_acc <= w_acc_n;
                    r_out_cnt <= w_cnt_n;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_cnt   = r_out_cnt;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mac_align_acc.sv
// Directed bench for mac_align_acc with hand-computed group results.
module tb_mac_align_acc;

    localparam int LANES = 4;
    localparam int AW    = 27;
    localparam int BW    = 27;
    localparam int SFTW  = 6;
    localparam int ACCW  = 82;
    localparam int CNTW  = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid, in_ready, in_first, in_last, in_sub;
    logic [LANES*AW-1:0]   in_a;
    logic [LANES*BW-1:0]   in_b;
    logic [LANES*SFTW-1:0] in_sft;
    logic                  out_valid, out_ready, proto_err, ovf;
    logic [ACCW-1:0]       out_acc;
    logic [CNTW-1:0]       out_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_perr = 0;
    logic [127:0] q_acc [$];
    logic [127:0] q_cnt [$];

    always #5 clk = ~clk;

    mac_align_acc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sub    (in_sub),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sft    (in_sft),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .proto_err (proto_err),
        .ovf       (ovf)
    );

    // Results are taken on the cycle they are handed over; proto_err pulses are tallied.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                q_acc.push_back(128'(out_acc));
                q_cnt.push_back(128'(out_cnt));
            end
            if (proto_err) n_perr++;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [LANES*AW-1:0] pk(input int unsigned v0, v1, v2, v3);
        pk = '0;
        pk[0*AW +: AW] = AW'(v0);
        pk[1*AW +: AW] = AW'(v1);
        pk[2*AW +: AW] = AW'(v2);
        pk[3*AW +: AW] = AW'(v3);
    endfunction

    function automatic logic [LANES*SFTW-1:0] sf4(input int unsigned s0, s1, s2, s3);
        sf4 = '0;
        sf4[0*SFTW +: SFTW] = SFTW'(s0);
        sf4[1*SFTW +: SFTW] = SFTW'(s1);
        sf4[2*SFTW +: SFTW] = SFTW'(s2);
        sf4[3*SFTW +: SFTW] = SFTW'(s3);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic f, input logic l, input logic s,
                             input logic [LANES*AW-1:0] a, input logic [LANES*BW-1:0] b,
                             input logic [LANES*SFTW-1:0] sft);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_sub   = s;
        in_a     = a;
        in_b     = b;
        in_sft   = sft;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check_val("accept_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [127:0] acc, input logic [127:0] cnt);
        for (int t = 0; t < 50 && q_acc.size() == 0; t++) begin
            @(negedge clk);
            #1;
        end
        if (q_acc.size() == 0) begin
            check_val({tag, "_timeout"}, 128'(0), 128'(1));
        end else begin
            check_val({tag, "_acc"}, q_acc.pop_front(), acc);
            check_val({tag, "_cnt"}, q_cnt.pop_front(), cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] all_ones;
        int           perr0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_sub    = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sft    = '0;
        out_ready = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);

        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_out_acc",   128'(out_acc),   128'(0));
        check_val("rst_out_cnt",   128'(out_cnt),   128'(0));
        check_val("rst_proto_err", 128'(proto_err), 128'(0));
        check_val("rst_ovf",       128'(ovf),       128'(0));
        check_val("rst_in_ready",  128'(in_ready),  128'(1));

        // 1: single-beat group, 9+25+49+81, three-cycle latency
        send_beat(1'b1, 1'b1, 1'b0, pk(3, 5, 7, 9), pk(3, 5, 7, 9), sf4(16, 16, 16, 16));
        check_val("t1_lat1", 128'(out_valid), 128'(0));
        step(1);
        check_val("t1_lat2", 128'(out_valid), 128'(0));
        step(1);
        check_val("t1_lat3", 128'(out_valid), 128'(1));
        expect_result("t1", 128'(164), 128'(1));

        // 2: +65536 -65536 +65536 with zero shift
        send_beat(1'b1, 1'b0, 1'b0, pk(1, 0, 0, 0), pk(1, 0, 0, 0), sf4(0, 0, 0, 0));
        send_beat(1'b0, 1'b0, 1'b1, pk(1, 0, 0, 0), pk(1, 0, 0, 0), sf4(0, 0, 0, 0));
        send_beat(1'b0, 1'b1, 1'b0, pk(1, 0, 0, 0), pk(1, 0, 0, 0), sf4(0, 0, 0, 0));
        expect_result("t2", 128'(65536), 128'(3));

        // 3: two queued single-beat groups behind a five-cycle output stall
        out_ready = 1'b0;
        send_beat(1'b1, 1'b1, 1'b0, pk(2, 0, 0, 0), pk(3, 0, 0, 0), sf4(16, 16, 16, 16));
        send_beat(1'b1, 1'b1, 1'b0, pk(4, 0, 0, 0), pk(5, 0, 0, 0), sf4(16, 16, 16, 16));
        for (int t = 0; t < 20 && !out_valid; t++) step(1);
        check_val("t3_valid", 128'(out_valid), 128'(1));
        for (int t = 0; t < 5; t++) begin
            check_val("t3_stall_ready", 128'(in_ready), 128'(0));
            check_val("t3_stall_acc",   128'(out_acc),  128'(6));
            step(1);
        end
        check_val("t3_none_early", 128'(q_acc.size()), 128'(0));
        out_ready = 1'b1;
        expect_result("t3a", 128'(6), 128'(1));
        expect_result("t3b", 128'(20), 128'(1));
        check_val("t3_no_perr", 128'(n_perr), 128'(0));

        // 4a: missing first in IDLE; lane0 32<<16>>20 = 2, lane1 1
        perr0 = n_perr;
        send_beat(1'b0, 1'b1, 1'b0, pk(32, 1, 0, 0), pk(1, 1, 0, 0), sf4(20, 16, 16, 16));
        expect_result("t4a", 128'(3), 128'(1));
        check_val("t4a_perr", 128'(n_perr - perr0), 128'(1));

        // 4b: restart mid-group discards the 7, keeps 2+3
        perr0 = n_perr;
        send_beat(1'b1, 1'b0, 1'b0, pk(7, 0, 0, 0), pk(1, 0, 0, 0), sf4(16, 16, 16, 16));
        send_beat(1'b1, 1'b0, 1'b0, pk(2, 0, 0, 0), pk(1, 0, 0, 0), sf4(16, 16, 16, 16));
        send_beat(1'b0, 1'b1, 1'b0, pk(3, 0, 0, 0), pk(1, 0, 0, 0), sf4(16, 16, 16, 16));
        expect_result("t4b", 128'(5), 128'(2));
        step(5);
        check_val("t4b_single", 128'(q_acc.size()), 128'(0));
        check_val("t4b_perr", 128'(n_perr - perr0), 128'(1));

        // 5: subtract 1 from an empty group wraps to all ones
        all_ones = '0;
        all_ones[ACCW-1:0] = '1;
        send_beat(1'b1, 1'b1, 1'b1, pk(1, 0, 0, 0), pk(1, 0, 0, 0), sf4(16, 16, 16, 16));
        expect_result("t5", all_ones, 128'(1));
        check_val("t5_ovf", 128'(ovf), 128'(0));

        // 6: reset while a complete group is still in the pipeline
        send_beat(1'b1, 1'b0, 1'b0, pk(9, 0, 0, 0), pk(9, 0, 0, 0), sf4(16, 16, 16, 16));
        send_beat(1'b0, 1'b1, 1'b0, pk(9, 0, 0, 0), pk(9, 0, 0, 0), sf4(16, 16, 16, 16));
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_val("t6_valid_after_rst", 128'(out_valid), 128'(0));
        step(6);
        check_val("t6_no_stale", 128'(q_acc.size()), 128'(0));
        check_val("t6_valid_idle", 128'(out_valid), 128'(0));
        send_beat(1'b1, 1'b0, 1'b0, pk(10, 1, 0, 0), pk(10, 2, 0, 0), sf4(16, 16, 16, 16));
        send_beat(1'b0, 1'b1, 1'b1, pk(2, 0, 0, 0), pk(1, 0, 0, 0), sf4(16, 16, 16, 16));
        expect_result("t6", 128'(100), 128'(2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
